// File: rtl/ex_div_ctrl_pkg.sv
// Shared constants for the EX-stage divide controller: FSM encodings and DIV/DIVU aluop codes.
// Latency: none (constants and pure functions only).
// Backpressure: n/a.
package ex_div_ctrl_pkg;

    // FSM encodings, kept as plain 2-bit constants so older EX code can compare against them.
    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_BUSY = 2'b01;
    localparam logic [1:0] DIV_FIX  = 2'b10;
    localparam logic [1:0] DIV_DONE = 2'b11;

    // aluop codes EX decodes to form start_i / signed_i.
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // EX helper: does this aluop need the divider at all.
    function automatic logic is_div_op(input logic [7:0] aluop);
        return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
    endfunction

    // EX helper: signed_i for a divide aluop.
    function automatic logic is_signed_div_op(input logic [7:0] aluop);
        return aluop == EXE_DIV_OP;
    endfunction

endpackage

// File: rtl/ex_div_ctrl_div_step.sv
// One restoring-division step: shift {rem,quo} left by one, trial-subtract the divisor, keep or restore.
// Latency: purely combinational.
// Backpressure: none; the controller decides when to register the result.
//
// Ports:
//   i_rem      partial remainder (always < divisor for a non-zero divisor)
//   i_quo      dividend bits still to shift in, quotient bits accumulated at the bottom
//   i_divisor  divisor magnitude
//   o_rem      next partial remainder
//   o_quo      next quotient/dividend word, new quotient bit in [0]
module ex_div_ctrl_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);

    logic [DATA_W:0]   w_shift;
    logic [DATA_W-1:0] w_trial;
    logic              w_borrow;

    assign w_shift  = {i_rem, i_quo[DATA_W-1]};
    // An explicit compare rather than the subtract's sign bit: with a zero divisor the
    // remainder grows without bound and the shifted value can use the extra top bit.
    assign w_borrow = (w_shift < {1'b0, i_divisor});
    // When there is no borrow the difference is below the divisor, so DATA_W bits suffice.
    assign w_trial  = w_shift[DATA_W-1:0] - i_divisor;

    assign o_rem = w_borrow ? w_shift[DATA_W-1:0] : w_trial;
    assign o_quo = {i_quo[DATA_W-2:0], ~w_borrow};

endmodule

// File: rtl/ex_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for EX: captures operand magnitudes, runs DATA_W restoring steps, fixes signs.
// Latency: ready_o DATA_W+2 cycles after start_i is sampled in IDLE (1 cycle for a zero divisor with DIV_ZERO_FAST_EN).
// Backpressure: stallreq_o holds the pipeline while start_i is pending; annul_i abandons the operation at any point.
//
// Optional feature macro: DIV_ZERO_FAST_EN (zero divisor completes immediately without iterating).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start_i      divide request from EX, held until ready_o
//   signed_i     1 = DIV, 0 = DIVU (sampled with start_i)
//   opdata1_i    dividend, opdata2_i divisor (sampled with start_i)
//   annul_i      flush the current operation
//   result_o     {hi=remainder, lo=quotient}, non-zero only while ready_o
//   ready_o      one-cycle result strobe
//   busy_o       controller not idle
//   stallreq_o   start_i & ~ready_o & ~annul_i
//   div_zero_o   divisor was zero, qualified by ready_o
module ex_div_ctrl
    import ex_div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  stallreq_o,
    output logic                  div_zero_o
);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;       // remainder magnitude, then signed hi after FIX
    logic [DATA_W-1:0] r_quo;       // dividend magnitude shifting out, quotient shifting in
    logic [DATA_W-1:0] r_divisor;
    logic              r_dvd_neg;   // signed op with negative dividend
    logic              r_dvs_neg;   // signed op with negative divisor
    logic              r_div_zero;

    logic              w_launch;
    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic              w_div_zero;
    logic              w_fast_zero;
    logic [DATA_W-1:0] w_op1_mag;
    logic [DATA_W-1:0] w_op2_mag;
    logic [DATA_W-1:0] w_step_rem;
    logic [DATA_W-1:0] w_step_quo;
    logic              w_done;

    assign w_launch   = start_i & ~annul_i;
    assign w_dvd_neg  = signed_i & opdata1_i[DATA_W-1];
    assign w_dvs_neg  = signed_i & opdata2_i[DATA_W-1];
    assign w_div_zero = (opdata2_i == '0);
    // Two's-complement negation of the most negative value yields itself, which read as an
    // unsigned DATA_W-bit magnitude is exactly right.
    assign w_op1_mag  = w_dvd_neg ? -opdata1_i : opdata1_i;
    assign w_op2_mag  = w_dvs_neg ? -opdata2_i : opdata2_i;

`ifdef DIV_ZERO_FAST_EN
    assign w_fast_zero = w_div_zero;
`else
    assign w_fast_zero = 1'b0;
`endif

    ex_div_ctrl_div_step #(
        .DATA_W    (DATA_W)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= DIV_IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_divisor  <= '0;
            r_dvd_neg  <= 1'b0;
            r_dvs_neg  <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_launch) begin
                        r_cnt      <= '0;
                        r_dvd_neg  <= w_dvd_neg;
                        r_dvs_neg  <= w_dvs_neg;
                        r_div_zero <= w_div_zero;
                        r_divisor  <= w_op2_mag;
                        if (w_fast_zero) begin
                            // Zero divisor short cut: hi is the raw dividend, lo all ones, no FIX.
                            r_rem   <= opdata1_i;
                            r_quo   <= '1;
                            r_state <= DIV_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_op1_mag;
                            r_state <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (annul_i) begin
                        r_state <= DIV_IDLE;
                    end else begin
                        r_rem <= w_step_rem;
                        r_quo <= w_step_quo;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            r_state <= DIV_FIX;
                        end
                    end
                end
                DIV_FIX: begin
                    if (annul_i) begin
                        r_state <= DIV_IDLE;
                    end else begin
                        // Sign flags are already gated by signed_i, so DIVU passes straight through.
                        if (r_dvd_neg ^ r_dvs_neg) begin
                            r_quo <= -r_quo;
                        end
                        if (r_dvd_neg) begin
                            r_rem <= -r_rem;
                        end
                        r_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    // start_i is deliberately ignored here; a held request relaunches from IDLE.
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign w_done     = (r_state == DIV_DONE);
    // A flush arriving in DONE suppresses the strobe so the annulled op never reports.
    assign ready_o    = w_done & ~annul_i;
    assign result_o   = ready_o ? {r_rem, r_quo} : '0;
    assign div_zero_o = ready_o & r_div_zero;
    assign busy_o     = (r_state != DIV_IDLE);
    assign stallreq_o = start_i & ~ready_o & ~annul_i;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl: scoreboard of expected {div_zero, hi, lo, ready cycle}.
// Latency: checks absolute ready cycle per operation.
// Backpressure: exercises stallreq_o, annul_i and a start_i held across DONE.
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic        stallreq_o;
    logic        div_zero_o;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          rdy_cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    ex_div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .stallreq_o (stallreq_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Reference: {div_zero, hi, lo}.
    function automatic logic [64:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        dz = 1'b0;
        if (b == 32'd0) begin
            dz = 1'b1;
            lo = 32'hFFFF_FFFF;
            hi = a;
`ifndef DIV_ZERO_FAST_EN
            // All-ones magnitude negated because the (positive) zero divisor differs in sign.
            if (s && a[31]) lo = 32'd1;
`endif
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000;
                hi = 32'd0;
            end else begin
                lo = $signed(a) / $signed(b);
                hi = $signed(a) % $signed(b);
            end
        end else begin
            lo = a / b;
            hi = a % b;
        end
        return {dz, hi, lo};
    endfunction

    // Drive a request and push its expectation; extra = cycles before the DUT can sample it.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b, input int extra);
        exp_t        e;
        logic [64:0] m;
        int          lat;
        m   = model(s, a, b);
        lat = 34;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) lat = 1;
`endif
        e.dz      = m[64];
        e.res     = m[63:0];
        e.rdy_cyc = cyc + extra + lat;
        sb.push_back(e);
        start_i   = 1'b1;
        signed_i  = s;
        opdata1_i = a;
        opdata2_i = b;
    endtask

    task automatic wait_ready(input string name);
        int   t0;
        bit   got;
        int   stall_bad;
        exp_t e;
        t0 = cyc;
        got = 0;
        stall_bad = 0;
        while (!got && (cyc - t0) < 200) begin
            tick();
            if (ready_o === 1'b1) got = 1;
            else if (start_i && !annul_i && stallreq_o !== 1'b1) stall_bad++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: ready_o not seen within 200 cycles", name);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            checks++;
            if (stall_bad != 0) begin
                errors++;
                $display("FAIL %s stallreq: low on %0d waiting cycles, required high", name, stall_bad);
            end
            checks++;
            if (stallreq_o !== 1'b0) begin
                errors++;
                $display("FAIL %s stallreq_at_ready: got %b, required 0", name, stallreq_o);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard: ready_o with no expected entry", name);
            end else begin
                e = sb.pop_front();
                if (result_o !== e.res) begin
                    errors++;
                    $display("FAIL %s result: got hi=%h lo=%h, required hi=%h lo=%h",
                             name, result_o[63:32], result_o[31:0], e.res[63:32], e.res[31:0]);
                end
                checks++;
                if (div_zero_o !== e.dz) begin
                    errors++;
                    $display("FAIL %s div_zero: got %b, required %b", name, div_zero_o, e.dz);
                end
                checks++;
                if (cyc != e.rdy_cyc) begin
                    errors++;
                    $display("FAIL %s latency: ready at cycle %0d, required %0d", name, cyc, e.rdy_cyc);
                end
            end
        end
    endtask

    // Drop the request and confirm the strobe lasted exactly one cycle.
    task automatic finish_op(input string name);
        start_i = 1'b0;
        tick();
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++;
            $display("FAIL %s pulse: ready=%b result=%h after DONE, required 0/0", name, ready_o, result_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: busy_o=%b after DONE, required 0", name, busy_o);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 64'd0 ||
            div_zero_o !== 1'b0 || stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b busy=%b result=%h dz=%b stall=%b, required all 0",
                     ready_o, busy_o, result_o, div_zero_o, stallreq_o);
        end
    endtask

    task automatic test_divu();
        launch(1'b0, 32'd100, 32'd7, 0);
        #1;
        checks++;
        if (stallreq_o !== 1'b1) begin
            errors++;
            $display("FAIL divu_stall_c0: got %b, required 1", stallreq_o);
        end
        wait_ready("divu_100_7");
        finish_op("divu_100_7");
        launch(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 0);
        wait_ready("divu_max_16");
        finish_op("divu_max_16");
    endtask

    task automatic test_signed();
        logic [31:0] a;
        logic [31:0] b;
        launch(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        wait_ready("div_m7_2");
        finish_op("div_m7_2");
        launch(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        wait_ready("div_7_m2");
        finish_op("div_7_m2");
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i < 3) ? 32'($urandom_range(1, 5000)) : $urandom;
            if (b == 32'd0) b = 32'd1;
            launch(i[0], a, b, 0);
            wait_ready("div_random");
            finish_op("div_random");
        end
    endtask

    task automatic test_div_zero();
        launch(1'b0, 32'd5, 32'd0, 0);
        wait_ready("divu_5_0");
        finish_op("divu_5_0");
        launch(1'b1, 32'hFFFF_FFFC, 32'd0, 0);
        wait_ready("div_m4_0");
        finish_op("div_m4_0");
    endtask

    task automatic test_annul();
        int t0;
        bit saw_rdy;
        saw_rdy   = 0;
        // annul in IDLE blocks the launch
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd40;
        opdata2_i = 32'd4;
        annul_i   = 1'b1;
        tick();
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL annul_idle: busy_o=%b, required 0", busy_o);
        end
        // annul mid-BUSY
        signed_i  = 1'b1;
        opdata1_i = 32'hFFFF_FC18;
        opdata2_i = 32'd3;
        annul_i   = 1'b0;
        t0 = cyc;
        while (cyc < t0 + 10) begin
            tick();
            if (ready_o === 1'b1) saw_rdy = 1;
        end
        annul_i = 1'b1;
        #1;
        checks++;
        if (stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL annul_stall: stallreq_o=%b under annul, required 0", stallreq_o);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL annul_busy: busy_o=%b at cycle 11, required 0", busy_o);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        repeat (30) begin
            tick();
            if (ready_o !== 1'b0) saw_rdy = 1;
        end
        checks++;
        if (saw_rdy) begin
            errors++;
            $display("FAIL annul_no_ready: ready_o seen for annulled op, required none");
        end
        launch(1'b0, 32'd9, 32'd3, 0);
        wait_ready("divu_9_3");
        finish_op("divu_9_3");
    endtask

    task automatic test_async_reset();
        start_i   = 1'b1;
        signed_i  = 1'b0;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        repeat (5) tick();
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: busy_o=%b mid-op, required 1", busy_o);
        end
        #2;
        rst     = 1'b1;
        start_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 64'd0 ||
            div_zero_o !== 1'b0 || stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: ready=%b busy=%b result=%h dz=%b stall=%b, required all 0",
                     ready_o, busy_o, result_o, div_zero_o, stallreq_o);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL areset_idle: busy_o=%b after release, required 0", busy_o);
        end
        launch(1'b0, 32'd81, 32'd9, 0);
        wait_ready("divu_81_9");
        finish_op("divu_81_9");
    endtask

    task automatic test_back_to_back();
        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        wait_ready("div_ovf");
        // start_i stays high; the next op is only sampled once the DUT is back in IDLE
        launch(1'b0, 32'd1000, 32'd10, 1);
        wait_ready("b2b_second");
        finish_op("b2b_second");
    endtask

    initial begin
        rst       = 1'b1;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        annul_i   = 1'b0;
        repeat (3) tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_divu();
        test_signed();
        test_div_zero();
        test_annul();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
